// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
//   tx_state_t         - transmitter FSM state encoding
//   START_BIT_VAL      - line level during the start bit
//   STOP_BIT_VAL       - line level during the stop bit and when idle
//   DEFAULT_BIT_PERIOD - clocks per serial bit unless overridden
//   DATA_BITS          - payload bits per frame
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic START_BIT_VAL      = 1'b0;
  localparam logic STOP_BIT_VAL       = 1'b1;
  localparam int   DEFAULT_BIT_PERIOD = 10;
  localparam int   DATA_BITS          = 8;

endpackage

// File: rtl/tx_bit_timer.sv
// tx_bit_timer: bit-period timer for the UART transmitter.
// Counts 0..BIT_PERIOD-1 while enabled and wraps; held at zero while disabled,
// so every frame starts with a fresh full-length first bit.
//   clk        in  system clock, rising edge
//   rst        in  synchronous active-high reset
//   enable     in  count while high, clear while low
//   bit_strobe out high in the last clock of every bit period
module tx_bit_timer
  import uart_pkg::*;
#(
  parameter int BIT_PERIOD = DEFAULT_BIT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bit_strobe
);

  localparam logic [7:0] TERM_CNT = 8'(BIT_PERIOD - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == TERM_CNT) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_strobe = enable && (cnt_q == TERM_CNT);

endmodule

// File: rtl/tx_block.sv
// tx_block: UART transmitter with a one-entry holding buffer.
// Frame = start bit (0), 8 data bits LSB first, stop bit (1); each bit lasts
// BIT_PERIOD clocks; line idles high.
//   clk        in  system clock, rising edge
//   rst        in  synchronous active-high reset; aborts any frame
//   tx_data    in  byte to send, sampled when tx_load=1
//   tx_load    in  write strobe for the holding buffer
//   tx_ready   out holding buffer empty (write accepted this cycle)
//   tx_busy    out a frame is on the line
//   load_error out one-cycle pulse after a write to a full buffer
//   tx_done    out one-cycle pulse in the last clock of a stop bit
//   serial_out out registered serial line
//
// state | meaning
// IDLE  | line high, waiting for a buffered byte
// START | start bit on the line
// DATA  | shifting out payload bits, LSB first
// STOP  | stop bit; at its end chain straight into the next buffered byte
module tx_block
  import uart_pkg::*;
#(
  parameter int BIT_PERIOD = DEFAULT_BIT_PERIOD,
  parameter int DATA_BITS  = uart_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_load,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 load_error,
  output logic                 tx_done,
  output logic                 serial_out
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 serial_q, serial_d;
  logic                 load_error_q, load_error_d;
  logic                 take;
  logic                 bit_strobe;

  tx_bit_timer #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .enable    (state_q != IDLE),
    .bit_strobe(bit_strobe)
  );

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    take         = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_valid_q) begin
          take    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_strobe) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_strobe) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end
      end
      STOP: begin
        if (bit_strobe) begin
          if (hold_valid_q) begin
            take    = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A transfer needs hold_valid_q=1, so it never coincides with an accepted write.
    if (take) begin
      shift_d      = hold_data_q;
      hold_valid_d = 1'b0;
    end else if (tx_load && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_data_d  = tx_data;
    end

    load_error_d = tx_load && hold_valid_q;

    // serial_out is registered, so derive it from the upcoming state.
    case (state_d)
      START:   serial_d = START_BIT_VAL;
      DATA:    serial_d = shift_d[0];
      default: serial_d = STOP_BIT_VAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      serial_q     <= STOP_BIT_VAL;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      serial_q     <= serial_d;
      load_error_q <= load_error_d;
    end
  end

  assign tx_ready   = !hold_valid_q;
  assign tx_busy    = (state_q != IDLE);
  assign tx_done    = (state_q == STOP) && bit_strobe;
  assign load_error = load_error_q;
  assign serial_out = serial_q;

endmodule

// File: tb/tb_tx_block.sv
// Testbench for tx_block: frame-timeline reference model plus a line decoder
// standing in for the receive path.
module tb_tx_block;

  localparam int BP    = 10;
  localparam int FRAME = 10 * BP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_load = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_busy, load_error, tx_done, serial_out;

  int total = 0;
  int bad   = 0;

  tx_block #(.BIT_PERIOD(BP)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .tx_ready  (tx_ready),
    .tx_busy   (tx_busy),
    .load_error(load_error),
    .tx_done   (tx_done),
    .serial_out(serial_out)
  );

  always #5 clk = ~clk;

  // Reference model: buffer flag/byte, and the active frame as a byte plus
  // a clock offset 0..FRAME-1 into it.
  logic       m_hv = 1'b0;
  logic [7:0] m_hb = 8'h00;
  logic       m_act = 1'b0;
  logic [7:0] m_fb = 8'h00;
  int         m_t = 0;
  logic       m_err = 1'b0;
  logic [7:0] done_q[$];

  // Line decoder (mid-bit sampling).
  logic       d_act = 1'b0;
  int         d_cnt = 0;
  logic [7:0] d_sh = 8'h00;
  int         ferr = 0;
  logic [7:0] rx_q[$];

  // {serial_out, tx_busy, tx_ready, tx_done, load_error}
  function automatic logic [4:0] model_vec();
    logic so;
    int   idx;
    so = 1'b1;
    if (m_act) begin
      idx = m_t / BP;
      if (idx == 0)      so = 1'b0;
      else if (idx <= 8) so = m_fb[idx-1];
      else               so = 1'b1;
    end
    return {so, m_act, !m_hv, m_act && (m_t == FRAME-1), m_err};
  endfunction

  task automatic tick(input logic ld, input logic [7:0] d, input logic r);
    logic hv0, fin, start_new;
    int   k;
    tx_load = ld;
    tx_data = d;
    rst     = r;
    @(posedge clk);
    hv0 = m_hv;
    if (r) begin
      m_hv = 1'b0; m_act = 1'b0; m_t = 0; m_err = 1'b0;
    end else begin
      fin = m_act && (m_t == FRAME-1);
      if (fin) done_q.push_back(m_fb);
      start_new = hv0 && (!m_act || fin);
      m_err = ld && hv0;
      if (start_new) begin
        m_fb = m_hb; m_t = 0; m_act = 1'b1; m_hv = 1'b0;
      end else if (fin) begin
        m_act = 1'b0; m_t = 0;
      end else if (m_act) begin
        m_t++;
      end
      if (ld && !hv0) begin
        m_hv = 1'b1; m_hb = d;
      end
    end
    #1;
    if (r) begin
      d_act = 1'b0;
      if (rx_q.size() > done_q.size()) void'(rx_q.pop_back());
    end else begin
      if (!d_act) begin
        if (serial_out == 1'b0) begin d_act = 1'b1; d_cnt = 0; end
      end else begin
        d_cnt++;
      end
      if (d_act && d_cnt >= BP/2 && ((d_cnt - BP/2) % BP) == 0) begin
        k = (d_cnt - BP/2) / BP;
        if (k == 0) begin
          if (serial_out !== 1'b0) ferr++;
        end else if (k <= 8) begin
          d_sh[k-1] = serial_out;
        end else begin
          if (serial_out !== 1'b1) ferr++;
          rx_q.push_back(d_sh);
          d_act = 1'b0;
        end
      end
    end
  endtask

  task automatic clear_logs();
    rx_q.delete();
    done_q.delete();
    ferr = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b1);
    total++;
    if ({serial_out, tx_busy, tx_ready, tx_done, load_error} !== 5'b10100) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", {serial_out, tx_busy, tx_ready, tx_done, load_error}, 5'b10100);
    end
    tick(1'b0, 8'h00, 1'b0);
    clear_logs();
  endtask

  task automatic test_single();
    logic [9:0] pat;
    int first_low, done_cyc, busy_n;
    pat = 10'b1101001010;
    first_low = -1; done_cyc = -1; busy_n = 0;
    clear_logs();
    for (int c = 0; c < 130; c++) begin
      total++;
      if ({serial_out, tx_busy, tx_ready, tx_done, load_error} !== model_vec()) begin
        bad++;
        $display("FAIL single_model c=%0d got=%b exp=%b", c, {serial_out, tx_busy, tx_ready, tx_done, load_error}, model_vec());
      end
      if (c >= 2 && c <= 101) begin
        total++;
        if (serial_out !== pat[(c-2)/BP]) begin
          bad++;
          $display("FAIL single_bit c=%0d got=%b exp=%b", c, serial_out, pat[(c-2)/BP]);
        end
      end
      if (serial_out === 1'b0 && first_low < 0) first_low = c;
      if (tx_done === 1'b1) done_cyc = c;
      if (tx_busy === 1'b1) busy_n++;
      tick(c == 0, 8'hA5, 1'b0);
    end
    total++;
    if (first_low != 2) begin bad++; $display("FAIL single_first_low got=%0d exp=2", first_low); end
    total++;
    if (done_cyc != 101) begin bad++; $display("FAIL single_done_cycle got=%0d exp=101", done_cyc); end
    total++;
    if (busy_n != 100) begin bad++; $display("FAIL single_busy_count got=%0d exp=100", busy_n); end
    total++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5 || ferr != 0) begin
      bad++; $display("FAIL single_rx got_n=%0d ferr=%0d exp=1 byte A5", rx_q.size(), ferr);
    end
  endtask

  task automatic test_back_to_back();
    int busy_n, nrdy_n;
    logic gap_ok;
    busy_n = 0; nrdy_n = 0; gap_ok = 1'b1;
    clear_logs();
    for (int c = 0; c < 230; c++) begin
      total++;
      if ({serial_out, tx_busy, tx_ready, tx_done, load_error} !== model_vec()) begin
        bad++;
        $display("FAIL b2b_model c=%0d got=%b exp=%b", c, {serial_out, tx_busy, tx_ready, tx_done, load_error}, model_vec());
      end
      if (tx_busy === 1'b1) busy_n++;
      if (tx_ready === 1'b0) begin
        nrdy_n++;
        if (!(c == 1 || (c >= 21 && c <= 101))) gap_ok = 1'b0;
      end
      if (c == 102) begin
        total++;
        if (serial_out !== 1'b0 || tx_busy !== 1'b1) begin
          bad++; $display("FAIL b2b_second_start got=%b%b exp=01", serial_out, tx_busy);
        end
      end
      tick(c == 0 || c == 20, (c == 0) ? 8'h3C : 8'hC3, 1'b0);
    end
    total++;
    if (busy_n != 200) begin bad++; $display("FAIL b2b_busy_count got=%0d exp=200", busy_n); end
    total++;
    if (nrdy_n != 82 || !gap_ok) begin bad++; $display("FAIL b2b_ready_low got=%0d exp=82 window_ok=%0b", nrdy_n, gap_ok); end
    total++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h3C || rx_q[1] !== 8'hC3 || ferr != 0) begin
      bad++; $display("FAIL b2b_rx got_n=%0d ferr=%0d exp=3C,C3", rx_q.size(), ferr);
    end
  endtask

  task automatic test_overrun();
    int err_n, err_cyc;
    logic [7:0] d;
    err_n = 0; err_cyc = -1;
    clear_logs();
    for (int c = 0; c < 230; c++) begin
      total++;
      if ({serial_out, tx_busy, tx_ready, tx_done, load_error} !== model_vec()) begin
        bad++;
        $display("FAIL overrun_model c=%0d got=%b exp=%b", c, {serial_out, tx_busy, tx_ready, tx_done, load_error}, model_vec());
      end
      if (load_error === 1'b1) begin err_n++; err_cyc = c; end
      d = (c == 0) ? 8'h11 : (c == 5) ? 8'h22 : 8'h33;
      tick(c == 0 || c == 5 || c == 6, d, 1'b0);
    end
    total++;
    if (err_n != 1 || err_cyc != 7) begin bad++; $display("FAIL overrun_error got_n=%0d at=%0d exp=1 at 7", err_n, err_cyc); end
    total++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22 || ferr != 0) begin
      bad++; $display("FAIL overrun_rx got_n=%0d ferr=%0d exp=11,22", rx_q.size(), ferr);
    end
  endtask

  task automatic test_reset_mid();
    int done_n;
    done_n = 0;
    clear_logs();
    for (int c = 0; c < 120; c++) begin
      total++;
      if ({serial_out, tx_busy, tx_ready, tx_done, load_error} !== model_vec()) begin
        bad++;
        $display("FAIL rstmid_model c=%0d got=%b exp=%b", c, {serial_out, tx_busy, tx_ready, tx_done, load_error}, model_vec());
      end
      if (c == 46) begin
        total++;
        if ({serial_out, tx_busy, tx_ready} !== 3'b101) begin
          bad++; $display("FAIL rstmid_after got=%b exp=101", {serial_out, tx_busy, tx_ready});
        end
      end
      if (tx_done === 1'b1) done_n++;
      tick(c == 0, 8'hFF, c == 45);
    end
    total++;
    if (done_n != 0 || rx_q.size() != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d rx=%0d exp=0", done_n, rx_q.size()); end
    for (int c = 0; c < 120; c++) begin
      total++;
      if ({serial_out, tx_busy, tx_ready, tx_done, load_error} !== model_vec()) begin
        bad++;
        $display("FAIL rstmid_reload c=%0d got=%b exp=%b", c, {serial_out, tx_busy, tx_ready, tx_done, load_error}, model_vec());
      end
      tick(c == 0, 8'h00, 1'b0);
    end
    total++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h00 || ferr != 0) begin
      bad++; $display("FAIL rstmid_rx got_n=%0d ferr=%0d exp=1 byte 00", rx_q.size(), ferr);
    end
  endtask

  task automatic test_loopback();
    clear_logs();
    for (int c = 0; c < 240; c++) begin
      total++;
      if ({serial_out, tx_busy, tx_ready, tx_done, load_error} !== model_vec()) begin
        bad++;
        $display("FAIL loop_model c=%0d got=%b exp=%b", c, {serial_out, tx_busy, tx_ready, tx_done, load_error}, model_vec());
      end
      tick(c == 0 || c == 37, (c == 0) ? 8'h5A : 8'h81, 1'b0);
    end
    total++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h5A || rx_q[1] !== 8'h81 || ferr != 0) begin
      bad++; $display("FAIL loop_rx got_n=%0d ferr=%0d exp=5A,81", rx_q.size(), ferr);
    end
  endtask

  task automatic test_idle();
    int ev;
    ev = 0;
    clear_logs();
    for (int c = 0; c < 500; c++) begin
      if (serial_out !== 1'b1 || tx_done !== 1'b0 || load_error !== 1'b0 || tx_busy !== 1'b0) ev++;
      tick(1'b0, 8'($urandom), 1'b0);
    end
    total++;
    if (ev != 0) begin bad++; $display("FAIL idle_quiet got=%0d events exp=0", ev); end
  endtask

  task automatic test_random();
    logic ld, r;
    clear_logs();
    for (int c = 0; c < 3300; c++) begin
      total++;
      if ({serial_out, tx_busy, tx_ready, tx_done, load_error} !== model_vec()) begin
        bad++;
        $display("FAIL rand_model c=%0d got=%b exp=%b", c, {serial_out, tx_busy, tx_ready, tx_done, load_error}, model_vec());
      end
      ld = (c < 3000) && ($urandom_range(0, 5) == 0);
      r  = (c < 3000) && ($urandom_range(0, 999) == 0);
      tick(ld, 8'($urandom), r);
    end
    total++;
    if (rx_q.size() != done_q.size() || ferr != 0) begin
      bad++; $display("FAIL rand_rx_count got=%0d exp=%0d ferr=%0d", rx_q.size(), done_q.size(), ferr);
    end else begin
      for (int i = 0; i < rx_q.size(); i++) begin
        total++;
        if (rx_q[i] !== done_q[i]) begin
          bad++; $display("FAIL rand_rx_byte i=%0d got=%h exp=%h", i, rx_q[i], done_q[i]);
        end
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_loopback();
    test_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
